// File: rtl/uart_tx_deq.sv
// rtl/uart_tx_deq.sv - UART transmitter draining a FIFO dequeue port, 8N1-style framing.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx_deq #(
  parameter int p_WORD_LEN    = 8,
  parameter int p_CLK_PER_BIT = 16,
  parameter int p_STOP_BITS   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_WORD_LEN-1:0] deq_data,
  input  logic                  deq_rdy,
  output logic                  deq_en,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(p_CLK_PER_BIT);
  localparam int IDX_W = $clog2(p_WORD_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(p_CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(p_WORD_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(p_STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_bit;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [p_WORD_LEN-1:0]   shreg;
  logic [p_WORD_LEN-1:0]   sh_next;

  assign sh_next = shreg >> 1;
  assign deq_en  = (state == IDLE) & deq_rdy & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (deq_en) begin
            shreg  <= deq_data;
`ifdef UART_TX_PARITY_EN
            // Parity taken from the word as popped; shreg is destroyed by shifting.
            par_bit <= ^deq_data;
`endif
            state  <= START;
            cnt    <= CNT_LOAD;
            o_tx   <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt     <= CNT_LOAD;
            bit_idx <= '0;
            state   <= DATA;
            o_tx    <= shreg[0];
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt   <= CNT_LOAD;
            shreg <= sh_next;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              o_tx  <= par_bit;
`else
              state <= STOP;
              o_tx  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              o_tx    <= sh_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt   <= CNT_LOAD;
            state <= STOP;
            o_tx  <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (bit_idx == LAST_STOP) begin
            // One guaranteed IDLE cycle follows, giving the +1 in the frame period.
            cnt     <= '0;
            bit_idx <= '0;
            state   <= IDLE;
            o_busy  <= 1'b0;
          end else begin
            cnt     <= CNT_LOAD;
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_deq.sv
// tb/tb_uart_tx_deq.sv - scoreboard bench for uart_tx_deq with a FIFO model and serial receiver monitor.
// Parity expectations follow UART_TX_PARITY_EN when defined.
module tb_uart_tx_deq;
  localparam int WL  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_BITS = 1 + WL + PB + SB;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic          i_clk;
  logic          i_rst;
  logic [WL-1:0] deq_data;
  logic          deq_rdy;
  logic          deq_en;
  logic          o_tx;
  logic          o_busy;

  uart_tx_deq #(.p_WORD_LEN(WL), .p_CLK_PER_BIT(CPB), .p_STOP_BITS(SB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .deq_data(deq_data), .deq_rdy(deq_rdy),
    .deq_en(deq_en), .o_tx(o_tx), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [WL-1:0] fifo_q[$];
  logic [WL-1:0] sb_q[$];
  int            pop_cyc[$];
  int            fall_cyc[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            pop_count = 0;
  int            en_run = 0;
  int            en_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WL-1:0] w, input bit expect_frame);
    @(negedge i_clk);
    #3;
    fifo_q.push_back(w);
    if (expect_frame) sb_q.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || o_busy !== 1'b0) && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    repeat (3) @(negedge i_clk);
    check(name, (t < 2000), 1);
  endtask

  task automatic wait_pops(input int n, input string name);
    int t;
    t = 0;
    while (pop_count < n && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    check(name, (t < 2000), 1);
  endtask

  // FIFO model: presents the head word, pops it after a posedge that saw deq_en.
  initial begin
    bit pend;
    pend = 1'b0;
    deq_rdy = 1'b0;
    deq_data = '0;
    forever begin
      @(negedge i_clk);
      if (pend) begin
        fifo_q.delete(0);
        pend = 1'b0;
      end
      deq_rdy = (fifo_q.size() > 0);
      deq_data = deq_rdy ? fifo_q[0] : '0;
      #1;
      if (deq_en === 1'b1) begin
        pend = 1'b1;
        pop_count++;
        pop_cyc.push_back(cyc);
        en_run++;
        if (en_run > en_max) en_max = en_run;
      end else begin
        en_run = 0;
      end
    end
  end

  // Serial receiver: captures one frame per start bit and checks it against the scoreboard.
  initial begin
    logic [FRAME_CYC-1:0] s;
    logic [WL-1:0]        rx;
    logic [WL-1:0]        exp_w;
    bit                   ab;
    bit                   busy_ok;
    bit                   cons;
    forever begin
      @(negedge i_clk);
      if (i_rst !== 1'b0 || o_tx !== 1'b0) continue;
      fall_cyc.push_back(cyc);
      s = '0;
      s[0] = o_tx;
      busy_ok = (o_busy === 1'b1);
      ab = 1'b0;
      for (int k = 1; k < FRAME_CYC; k++) begin
        @(negedge i_clk);
        if (i_rst !== 1'b0) begin
          ab = 1'b1;
          break;
        end
        s[k] = o_tx;
        if (o_busy !== 1'b1) busy_ok = 1'b0;
      end
      if (ab) continue;
      @(negedge i_clk);
      check("idle_after_frame", {30'd0, o_busy, o_tx}, 32'd1);
      check("busy_through_frame", busy_ok, 1);
      cons = 1'b1;
      for (int b = 0; b < FRAME_BITS; b++)
        for (int c = 1; c < CPB; c++)
          if (s[b*CPB+c] !== s[b*CPB]) cons = 1'b0;
      check("bit_width_stable", cons, 1);
      for (int i = 0; i < WL; i++) rx[i] = s[(1+i)*CPB];
      for (int j = 0; j < SB; j++) check("stop_bit", s[(1+WL+PB+j)*CPB], 1);
      if (PB != 0) check("parity_bit", s[(1+WL)*CPB], ^rx);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got %0h, expected no frame", rx);
      end else begin
        exp_w = sb_q.pop_front();
        check("frame_data", rx, exp_w);
      end
    end
  end

  initial begin
    int np;
    int busy_cnt;
    int en_cnt;
    int bad;

    // Async reset with no clock edge yet.
    i_rst = 1'b0;
    #2 i_rst = 1'b1;
    #1 check("reset_outputs", {29'd0, o_tx, o_busy, deq_en}, 32'h4);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Single word 0xA5.
    push(8'hA5, 1'b1);
    busy_cnt = 0;
    en_cnt = 0;
    repeat (FRAME_CYC + 20) begin
      @(negedge i_clk);
      #2;
      if (o_busy === 1'b1) busy_cnt++;
      if (deq_en === 1'b1) en_cnt++;
    end
    check("a5_busy_cycles", busy_cnt, FRAME_CYC);
    check("a5_deq_en_cycles", en_cnt, 1);
    check("a5_fall_latency", fall_cyc[0] - pop_cyc[0], 1);
    wait_drain("a5_drain");

    // Back-to-back words.
    np = pop_count;
    fork
      begin
        @(negedge i_clk);
        #3;
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h80); fifo_q.push_back(8'hFF);
        sb_q.push_back(8'h01); sb_q.push_back(8'h80); sb_q.push_back(8'hFF);
      end
    join
    wait_pops(np + 3, "b2b_pops_timeout");
    @(negedge i_clk);
    #2;
    check("b2b_fifo_empty", fifo_q.size(), 0);
    wait_drain("b2b_drain");
    check("b2b_pop_count", pop_count - np, 3);
    check("b2b_period_1", pop_cyc[np+1] - pop_cyc[np], FRAME_CYC + 1);
    check("b2b_period_2", pop_cyc[np+2] - pop_cyc[np+1], FRAME_CYC + 1);

    // Empty FIFO.
    np = pop_count;
    bad = 0;
    repeat (200) begin
      @(negedge i_clk);
      #2;
      if (deq_en !== 1'b0 || o_tx !== 1'b1) bad++;
    end
    check("empty_idle_violations", bad, 0);
    check("empty_no_pops", pop_count - np, 0);

    // Reset during data bit 3 of 0x3C, then a clean 0x55.
    np = pop_count;
    push(8'h3C, 1'b0);
    wait_pops(np + 1, "rst_pop_timeout");
    repeat (17) @(negedge i_clk);
    #2;
    check("rst_pre_bit3", {31'd0, o_tx}, 1);
    #1 i_rst = 1'b1;
    #1 check("rst_mid_frame", {29'd0, o_tx, o_busy, deq_en}, 32'h4);
    push(8'h55, 1'b1);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    wait_drain("rst_drain");
    check("rst_pop_count", pop_count - np, 2);
    check("deq_en_max_width", en_max, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end
endmodule
